// File: rtl/chord_pkg.sv
// Shared chord-interface definitions: voice geometry, FSM state codes and the
// rest note code. Reused by the song reader, chord_scheduler and note players.
package chord_pkg;

   localparam int NOTE_WIDTH     = 6;
   localparam int DURATION_WIDTH = 6;
   localparam int VOICES         = 3;
   localparam int SWIDTH         = 2;

   localparam logic [NOTE_WIDTH-1:0] REST = '0;

   typedef enum logic [SWIDTH-1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/voice_timer.sv
// One voice of a chord: latched note/duration, beat down-counter and active
// flag. Optional macro CHORD_SCHED_RELEASE_GAP_EN silences a voice of
// duration >= 2 one beat early (articulation gap); counting is unaffected.
module voice_timer
   import chord_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      load,
   input  logic                      tick,
   input  logic                      freeze,
   input  logic [NOTE_WIDTH-1:0]     note_in,
   input  logic [DURATION_WIDTH-1:0] duration_in,
   output logic                      active,
   output logic                      expired,
   output logic [NOTE_WIDTH-1:0]     note
);

   logic [NOTE_WIDTH-1:0]     note_q;
   logic [DURATION_WIDTH-1:0] count;
   logic                      live;

   // Latch the voice on load; a rest loads a zero count so it never sounds.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         note_q <= '0;
         count  <= '0;
      end else if (load) begin
         note_q <= note_in;
         count  <= (note_in != REST) ? duration_in : '0;
      end else if (tick && !freeze && (count != '0)) begin
         count <= count - DURATION_WIDTH'(1);
      end
   end

   assign live    = (count != '0);
   // Expired now, or about to be by the beat being counted this cycle.
   assign expired = !live || (tick && !freeze && (count == DURATION_WIDTH'(1)));

`ifdef CHORD_SCHED_RELEASE_GAP_EN
   logic single_beat;

   // Remember whether this voice was a one-beat note; those get no gap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         single_beat <= 1'b0;
      end else if (load) begin
         single_beat <= (duration_in == DURATION_WIDTH'(1));
      end
   end

   assign active = (count > DURATION_WIDTH'(1)) ||
                   ((count == DURATION_WIDTH'(1)) && single_beat);
`else
   assign active = live;
`endif

   assign note = active ? note_q : REST;

endmodule

// File: rtl/chord_scheduler.sv
// Chord scheduler: accepts a VOICES-wide chord bundle, loads one voice_timer
// per voice and pulses note_done once every voice has expired.
// Optional macro CHORD_SCHED_RELEASE_GAP_EN (handled inside voice_timer).
module chord_scheduler
   import chord_pkg::*;
(
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             play,
   input  logic                             beat,
   input  logic                             new_note,
   input  logic [VOICES*NOTE_WIDTH-1:0]     notes_in,
   input  logic [VOICES*DURATION_WIDTH-1:0] durations_in,
   output logic [VOICES*NOTE_WIDTH-1:0]     voice_note,
   output logic [VOICES-1:0]                voice_load,
   output logic [VOICES-1:0]                voice_active,
   output logic                             note_done,
   output logic                             busy
);

   state_t            state, next_state;
   logic              accept;
   logic              tick;
   logic [VOICES-1:0] expired;

   // A new bundle is taken in any state except LOAD; it pre-empts a beat.
   assign accept = new_note && play && (state != LOAD);
   assign tick   = beat && play && (state == RUN) && !accept;

   for (genvar i = 0; i < VOICES; i++) begin : g_voice
      voice_timer u_voice (
         .clk         (clk),
         .reset       (reset),
         .load        (accept),
         .tick        (tick),
         .freeze      (!play),
         .note_in     (notes_in[(VOICES-i)*NOTE_WIDTH-1 -: NOTE_WIDTH]),
         .duration_in (durations_in[(VOICES-i)*DURATION_WIDTH-1 -: DURATION_WIDTH]),
         .active      (voice_active[i]),
         .expired     (expired[i]),
         .note        (voice_note[(VOICES-i)*NOTE_WIDTH-1 -: NOTE_WIDTH])
      );
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and pulse outputs; voices are loaded at the accept edge so
   // they are already visible during LOAD.
   always_comb begin
      next_state = state;
      voice_load = '0;
      note_done  = 1'b0;
      case (state)
         IDLE: if (accept) next_state = LOAD;
         LOAD: begin
            voice_load = ~expired;
            next_state = (&expired) ? DONE : RUN;
         end
         RUN: begin
            if (accept)         next_state = LOAD;
            else if (&expired)  next_state = DONE;
         end
         DONE: begin
            if (accept) begin
               next_state = LOAD;
            end else begin
               note_done  = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

endmodule
